// File: rtl/circuit1_pkg.sv
// Shared constants and FSM encoding for the circuit_1 sweep controller and its bench.
package circuit1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;

    // Golden truth table of circuit_1 (majority of a,b,c), bit i = y for input value i.
    localparam logic [7:0] CIRCUIT1_EXPECTED = 8'hE8;

endpackage

// File: rtl/circuit1_sweep_ctrl_if.sv
// Handshake/bus bundle between the sweep controller, circuit_1 and its user.
interface circuit1_sweep_ctrl_if
    import circuit1_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic [N_IN-1:0]      drive;
    logic                 y_in;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   table_out;
    logic [2**N_IN-1:0]   mismatch_mask;
    logic                 pass;

    modport master (
        output start, expected, y_in,
        input  drive, busy, done, table_out, mismatch_mask, pass
    );

    modport slave (
        input  start, expected, y_in,
        output drive, busy, done, table_out, mismatch_mask, pass
    );
endinterface

// File: rtl/circuit1_vec_seq.sv
// Vector index counter plus index->drive-code mapping.
// Build option SWEEP_GRAY_EN: drive in Gray order so one circuit_1 input toggles per step.
module circuit1_vec_seq #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_inc,
    output logic [N_IN-1:0] o_code,
    output logic            o_last
);
    logic [N_IN-1:0] r_idx;
    logic [N_IN-1:0] r_code;
    logic [N_IN-1:0] w_idx_nxt;

    function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] v);
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    assign w_idx_nxt = r_idx + N_IN'(1);

    // r_code is the registered drive value; it holds after the sweep and clears only on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_code <= '0;
        end else if (i_load) begin
            r_idx  <= '0;
            r_code <= code('0);
        end else if (i_inc) begin
            r_idx  <= w_idx_nxt;
            r_code <= code(w_idx_nxt);
        end
    end

    assign o_code = r_code;
    assign o_last = (r_idx == '1);
endmodule

// File: rtl/circuit1_sweep_ctrl.sv
// Sweeps every input combination through circuit_1, captures its truth table and
// compares it with a golden table. Build option SWEEP_GRAY_EN selects Gray drive order.
module circuit1_sweep_ctrl
    import circuit1_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    circuit1_sweep_ctrl_if.slave  bus
);
    localparam int TW = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sweep_state_t     r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [TW-1:0]    r_expected, r_table, r_mask, w_table_upd;
    logic             r_busy, r_done, r_pass;
    logic             w_load, w_inc, w_last, w_settled;
    logic [N_IN-1:0]  w_code;

    circuit1_vec_seq #(.N_IN(N_IN)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_inc  (w_inc),
        .o_code (w_code),
        .o_last (w_last)
    );

    assign w_settled = (r_cnt == CW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_table_upd = r_table;
        // table is indexed by the applied input value, not the step number
        w_table_upd[w_code] = bus.y_in;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_DRIVE;
                    w_load = 1'b1;
                end
            end
            ST_DRIVE:  if (w_settled) w_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_DRIVE;
                    w_inc  = 1'b1;
                end
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_mask     <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_DRIVE) || (w_next == ST_SAMPLE);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_expected <= bus.expected;
                        r_table    <= '0;
                        r_mask     <= '0;
                        r_pass     <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                ST_DRIVE: if (!w_settled) r_cnt <= r_cnt + CW'(1);
                ST_SAMPLE: begin
                    r_table <= w_table_upd;
                    if (w_last) begin
                        r_mask <= w_table_upd ^ r_expected;
                        r_pass <= ((w_table_upd ^ r_expected) == '0);
                    end else begin
                        r_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.drive         = w_code;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.table_out     = r_table;
    assign bus.mismatch_mask = r_mask;
    assign bus.pass          = r_pass;
endmodule

// File: tb/tb_circuit1_sweep_ctrl.sv
// Scoreboard bench for circuit1_sweep_ctrl with a majority-gate model of circuit_1.
module tb_circuit1_sweep_ctrl;
    import circuit1_pkg::*;

    localparam int S  = 2;
    localparam int TW = 8;

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] mask;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    circuit1_sweep_ctrl_if #(.N_IN(3)) bus ();
    circuit1_sweep_ctrl_if #(.N_IN(3)) bus1 ();

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    assign bus.y_in  = maj(bus.drive);
    assign bus1.y_in = maj(bus1.drive);

    circuit1_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    circuit1_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Expected drive value at step k, hand-listed for each build.
    function automatic logic [2:0] code_of(input int k);
        logic [2:0] gray [8];
        gray = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        if (k < 0 || k > 7) return 3'bxxx;
`ifdef SWEEP_GRAY_EN
        return gray[k];
`else
        return 3'(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (bus.done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    // Monitor: checks the drive trace while busy and pops the scoreboard on every done.
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                chk("drive", bus.drive, code_of(busy_cnt / (S + 1)));
                busy_cnt++;
            end
            if (bus.done === 1'b1) begin
                chk("busy_in_done", bus.busy, 0);
                chk("latency", busy_cnt, TW * (S + 1));
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("table_out", bus.table_out, e.tbl);
                    chk("mismatch_mask", bus.mismatch_mask, e.mask);
                    chk("pass", bus.pass, e.pass);
                end
            end
            if (bus.busy !== 1'b1 && bus.done !== 1'b1) busy_cnt = 0;
        end
    end

    initial begin
        int low, dn, n;
        bus.start = 1'b0;  bus.expected = '0;
        bus1.start = 1'b0; bus1.expected = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_drive", bus.drive, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_table", bus.table_out, 0);
        chk("rst_mask", bus.mismatch_mask, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst1_table", bus1.table_out, 0);

        // 1: matching golden table
        rst = 1'b0;
        bus.expected = CIRCUIT1_EXPECTED;
        bus.start = 1'b1;
        exp_q.push_back('{8'hE8, 8'h00, 1'b1});
        @(negedge clk); bus.start = 1'b0;
        wait_done(40);

        // 2: golden table off in bit 0, results must hold afterwards
        @(negedge clk);
        bus.expected = 8'hE9;
        bus.start = 1'b1;
        exp_q.push_back('{8'hE8, 8'h01, 1'b0});
        @(negedge clk); bus.start = 1'b0;
        wait_done(40);
        repeat (5) @(negedge clk);
        chk("hold_table", bus.table_out, 8'hE8);
        chk("hold_mask", bus.mismatch_mask, 8'h01);
        chk("hold_pass", bus.pass, 0);
        chk("hold_drive", bus.drive, code_of(7));

        // 3: start held for 60 edges -> sweeps accepted at edges 0, 26, 52
        bus.expected = CIRCUIT1_EXPECTED;
        bus.start = 1'b1;
        repeat (3) exp_q.push_back('{8'hE8, 8'h00, 1'b1});
        low = 0; dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) low++;
            if (bus.done === 1'b1) dn++;
        end
        bus.start = 1'b0;
        chk("b2b_busy_low", low, 4);
        chk("b2b_done_cnt", dn, 2);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain", exp_q.size(), 0);

        // 4: reset at edge 10 of a sweep
        @(negedge clk);
        bus.expected = 8'hE9;
        bus.start = 1'b1;
        exp_q.push_back('{8'hE8, 8'h01, 1'b0});
        @(negedge clk); bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_drive", bus.drive, 0);
        chk("mid_rst_table", bus.table_out, 0);
        chk("mid_rst_done", bus.done, 0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        repeat (30) @(negedge clk);
        bus.expected = CIRCUIT1_EXPECTED;
        bus.start = 1'b1;
        exp_q.push_back('{8'hE8, 8'h00, 1'b1});
        @(negedge clk); bus.start = 1'b0;
        wait_done(40);

        // 6: SETTLE_CYCLES=1 instance
        @(negedge clk);
        bus1.expected = CIRCUIT1_EXPECTED;
        bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        n = 0;
        while (bus1.done !== 1'b1 && n < 40) begin
            chk("s1_drive", bus1.drive, code_of(n / 2));
            n++;
            @(negedge clk);
        end
        chk("s1_latency", n, 16);
        chk("s1_table", bus1.table_out, 8'hE8);
        chk("s1_mask", bus1.mismatch_mask, 8'h00);
        chk("s1_pass", bus1.pass, 1);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
